// File: rtl/digital_clock.sv
// 24-hour HH:MM:SS counter advanced by a prescaled one-second tick.
// Optional time-set port group compiled in with `define DIGITAL_CLOCK_SET_EN.
module digital_clock #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
`ifdef DIGITAL_CLOCK_SET_EN
  input  logic       load,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
`endif
  output logic [5:0] out_sec,
  output logic [5:0] out_min,
  output logic [4:0] out_hour
);

  localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] prescale_r;
  logic [PW-1:0] prescale_next_s;
  logic [5:0]    sec_next_s;
  logic [5:0]    min_next_s;
  logic [4:0]    hour_next_s;
  logic          tick_s;

  // Next-state: prescaler advance, tick carry chain, optional load override
  always_comb begin
    prescale_next_s = prescale_r + PW'(1);
    sec_next_s      = out_sec;
    min_next_s      = out_min;
    hour_next_s     = out_hour;
    tick_s          = (prescale_r >= PS_LAST);

    if (tick_s) begin
      prescale_next_s = '0;
      // >= comparisons keep any stray value inside the legal range
      if (out_sec >= 6'd59) begin
        sec_next_s = 6'd0;
        if (out_min >= 6'd59) begin
          min_next_s = 6'd0;
          if (out_hour >= 5'd23) begin
            hour_next_s = 5'd0;
          end else begin
            hour_next_s = out_hour + 5'd1;
          end
        end else begin
          min_next_s = out_min + 6'd1;
        end
      end else begin
        sec_next_s = out_sec + 6'd1;
      end
    end else begin
      prescale_next_s = prescale_r + PW'(1);
    end

`ifdef DIGITAL_CLOCK_SET_EN
    // A load wins over a coincident tick and restarts the second
    if (load) begin
      prescale_next_s = '0;
      sec_next_s      = (set_sec  > 6'd59) ? 6'd0 : set_sec;
      min_next_s      = (set_min  > 6'd59) ? 6'd0 : set_min;
      hour_next_s     = (set_hour > 5'd23) ? 5'd0 : set_hour;
    end else begin
      prescale_next_s = prescale_next_s;
    end
`endif
  end

  // State registers; reset has priority over load and tick
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_r <= '0;
      out_sec    <= 6'd0;
      out_min    <= 6'd0;
      out_hour   <= 5'd0;
    end else begin
      prescale_r <= prescale_next_s;
      out_sec    <= sec_next_s;
      out_min    <= min_next_s;
      out_hour   <= hour_next_s;
    end
  end

endmodule

// File: tb/tb_digital_clock.sv
// Directed bench for digital_clock at CLK_FREQ_HZ=10; load checks run only
// when DIGITAL_CLOCK_SET_EN is defined.
module tb_digital_clock;

  logic       clk;
  logic       reset;
  logic [5:0] out_sec;
  logic [5:0] out_min;
  logic [4:0] out_hour;
`ifdef DIGITAL_CLOCK_SET_EN
  logic       load;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
`endif

  int total = 0;
  int bad   = 0;

  digital_clock #(.CLK_FREQ_HZ(10)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef DIGITAL_CLOCK_SET_EN
    .load     (load),
    .set_hour (set_hour),
    .set_min  (set_min),
    .set_sec  (set_sec),
`endif
    .out_sec  (out_sec),
    .out_min  (out_min),
    .out_hour (out_hour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    int          edges;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    total++;
    if (out_hour !== h || out_min !== m || out_sec !== s) begin
      bad++;
      $display("FAIL %s: got %0d:%0d:%0d want %0d:%0d:%0d", nm, out_hour, out_min, out_sec, h, m, s);
    end
  endtask

  task automatic run(input logic rst, input int n);
    reset = rst;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

`ifdef DIGITAL_CLOCK_SET_EN
  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load = 1'b1; set_hour = h; set_min = m; set_sec = s;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask
`endif

  // Range watchdog on every sample point
  always @(negedge clk) begin
    total++;
    if (out_sec > 6'd59 || out_min > 6'd59 || out_hour > 5'd23) begin
      bad++;
      $display("FAIL range: got %0d:%0d:%0d", out_hour, out_min, out_sec);
    end
  end

  initial begin
    reset = 1'b1;
`ifdef DIGITAL_CLOCK_SET_EN
    load = 1'b0; set_hour = 5'd0; set_min = 6'd0; set_sec = 6'd0;
`endif
    vecs[0]  = '{"rst_hold3",     1'b1, 3,     5'd0, 6'd0, 6'd0};
    vecs[1]  = '{"pre_tick9",     1'b0, 9,     5'd0, 6'd0, 6'd0};
    vecs[2]  = '{"first_tick",    1'b0, 1,     5'd0, 6'd0, 6'd1};
    vecs[3]  = '{"second_tick",   1'b0, 10,    5'd0, 6'd0, 6'd2};
    vecs[4]  = '{"sixty_ticks",   1'b0, 580,   5'd0, 6'd1, 6'd0};
    vecs[5]  = '{"hour_ticks",    1'b0, 35400, 5'd1, 6'd0, 6'd0};
    vecs[6]  = '{"run_1_0_7",     1'b0, 75,    5'd1, 6'd0, 6'd7};
    vecs[7]  = '{"rst_from_hour", 1'b1, 1,     5'd0, 6'd0, 6'd0};
    vecs[8]  = '{"run_0_0_7",     1'b0, 75,    5'd0, 6'd0, 6'd7};
    vecs[9]  = '{"rst_midscale",  1'b1, 1,     5'd0, 6'd0, 6'd0};
    vecs[10] = '{"post_rst9",     1'b0, 9,     5'd0, 6'd0, 6'd0};
    vecs[11] = '{"post_rst10",    1'b0, 1,     5'd0, 6'd0, 6'd1};
    vecs[12] = '{"to_tick_edge",  1'b0, 9,     5'd0, 6'd0, 6'd1};
    vecs[13] = '{"rst_on_tick",   1'b1, 1,     5'd0, 6'd0, 6'd0};
    vecs[14] = '{"rst_held24",    1'b1, 24,    5'd0, 6'd0, 6'd0};
    vecs[15] = '{"release_tick",  1'b0, 10,    5'd0, 6'd0, 6'd1};
    vecs[16] = '{"sec_wrap",      1'b0, 590,   5'd0, 6'd1, 6'd0};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      run(vecs[i].rst, vecs[i].edges);
      check(vecs[i].name, vecs[i].h, vecs[i].m, vecs[i].s);
    end

`ifdef DIGITAL_CLOCK_SET_EN
    do_load(5'd23, 6'd59, 6'd58);
    check("load_235958", 5'd23, 6'd59, 6'd58);
    run(1'b0, 10);
    check("to_235959", 5'd23, 6'd59, 6'd59);
    run(1'b0, 10);
    check("day_wrap", 5'd0, 6'd0, 6'd0);
    run(1'b0, 9);
    check("before_tick", 5'd0, 6'd0, 6'd0);
    do_load(5'd12, 6'd34, 6'd56);
    check("load_on_tick", 5'd12, 6'd34, 6'd56);
    run(1'b0, 9);
    check("after_load9", 5'd12, 6'd34, 6'd56);
    run(1'b0, 1);
    check("after_load10", 5'd12, 6'd34, 6'd57);
    do_load(5'd25, 6'd61, 6'd70);
    check("load_all_bad", 5'd0, 6'd0, 6'd0);
    do_load(5'd23, 6'd59, 6'd60);
    check("load_sec_bad", 5'd23, 6'd59, 6'd0);
    reset = 1'b1;
    do_load(5'd5, 6'd5, 6'd5);
    check("rst_over_load", 5'd0, 6'd0, 6'd0);
    run(1'b0, 10);
    check("tick_after_rst", 5'd0, 6'd0, 6'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digital_clock.md
DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 SHALL provide parameter CLK_FREQ_HZ, default 100_000_000, input clock cycles per one-second tick; legal range ≥ 2.
REQ-002 SHALL provide port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL provide port out_sec, output, 6 bits, seconds count, unsigned binary 0..59.
REQ-005 SHALL provide port out_min, output, 6 bits, minutes count, unsigned binary 0..59.
REQ-006 SHALL provide port out_hour, output, 5 bits, hours count, unsigned binary 0..23 in 24-hour format.
REQ-007 SHALL provide port load, input, 1 bit, time-set strobe; present only with DIGITAL_CLOCK_SET_EN.
REQ-008 SHALL provide ports set_hour[4:0], set_min[5:0] and set_sec[5:0], all inputs, giving the value to load; present only with DIGITAL_CLOCK_SET_EN.

Function
REQ-009 SHALL drive all outputs directly from registers, with no combinational path from any input to any output.
REQ-010 SHALL contain a prescaler that counts 0..CLK_FREQ_HZ-1 and wraps to 0; its width is $clog2(CLK_FREQ_HZ).
REQ-011 SHALL generate an internal tick on the edge where the prescaler equals CLK_FREQ_HZ-1; seconds advance on that same edge.
REQ-012 SHALL make the first tick after reset release occur exactly CLK_FREQ_HZ rising edges after the first edge with reset low, so out_sec=1 follows that edge.
REQ-013 SHALL, on a tick with out_sec<59, increment out_sec only.
REQ-014 SHALL, on a tick with out_sec=59, set out_sec to 0 and increment out_min.
REQ-015 SHALL, on a tick with out_sec=59 and out_min=59, set both to 0 and increment out_hour.
REQ-016 SHALL, on a tick at 23:59:59, wrap to 00:00:00 on the same edge.
REQ-017 SHALL never present out_sec or out_min >59 or out_hour >23, under any input sequence.
REQ-018 SHALL, on an edge with load=1 and reset=0, load the set values, clear the prescaler to 0 and suppress any coincident tick.
REQ-019 SHALL load 0 for any set field that is out of range (set_sec>59, set_min>59, set_hour>23); in-range fields load normally.
REQ-020 SHALL give the next tick after a load exactly CLK_FREQ_HZ edges after the load edge.

Reset
REQ-021 SHALL, on any rising edge with reset=1, set out_sec=0, out_min=0, out_hour=0 and prescaler=0.
REQ-022 SHALL give reset priority over load and tick, including a reset asserted mid-prescale or in the same cycle as a tick or a load.
REQ-023 SHALL keep outputs at 00:00:00 while reset is held, with no ticks counted.

Configuration
REQ-024 SHALL, with macro DIGITAL_CLOCK_SET_EN defined, compile in the load and set_* ports and the behaviour of REQ-018..REQ-020.
REQ-025 SHALL, without DIGITAL_CLOCK_SET_EN, omit the load and set_* ports entirely, leaving the clock as a free-running counter with reset as its only control.

Verification
REQ-026 SHALL cover: CLK_FREQ_HZ=10, reset high 3 edges then low -> 00:00:00 during reset; out_sec=1 after exactly 10 edges; out_sec=2 after 20 edges.
REQ-027 SHALL cover: CLK_FREQ_HZ=10, free run of 60 ticks -> 00:01:00; 3600 ticks -> 01:00:00.
REQ-028 SHALL cover: SET_EN, load 23:59:58 -> 23:59:59 after 10 edges, 00:00:00 after 20 edges.
REQ-029 SHALL cover: reset asserted 1 edge with the prescaler at 5, from 00:00:07 -> 00:00:00; next tick exactly 10 edges after release.
REQ-030 SHALL cover: SET_EN, load 25:61:70 -> 00:00:00; load 12:34:56 on a tick edge -> 12:34:56, with no increment on that edge.
REQ-031 SHALL cover: default CLK_FREQ_HZ at a 10 ns clock -> out_sec=1 at 1 s of simulated time after reset release, and no out-of-range value ever appears.
